// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the IF/MEM memory controller: state and length encodings,
// legacy word-size constants and the transfer byte-count helper.
package mem_ctrl_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_RD  = 2'd1;
    localparam logic [1:0] MEM_RD = 2'd2;
    localparam logic [1:0] MEM_WR = 2'd3;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // 2'b11 is treated as a full word
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM bus bundle of mem_ctrl; master = requesters + RAM, slave = controller.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = InstLen,
    parameter int RAM_DW = 8
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_inst;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    logic [RAM_DW-1:0] ram_din;
    logic [RAM_DW-1:0] ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport master (
        output if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, busy, ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, busy, ram_dout, ram_a, ram_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Single-port RAM controller arbitrating instruction fetch and data access,
// serialising little-endian 1/2/4-byte transfers over an 8-bit synchronous RAM.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = InstLen,
    parameter int RAM_DW = 8
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    input logic       flush,
    mem_ctrl_if.slave bus
);

    localparam int NB = DATA_W / RAM_DW;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [2:0]        step;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [RAM_DW-1:0] ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        addr_d      = addr_q;
        ram_a_d     = ram_a_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_done_d   = False;
        mem_done_d  = False;
        busy_d      = busy_q;
        // step is the index k of the edge being evaluated (acceptance edge is k=0)
        step        = cnt_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (!if_done_q && !mem_done_q) begin
                    if (bus.mem_req) begin
                        addr_d   = bus.mem_addr;
                        ram_a_d  = bus.mem_addr;
                        nbytes_d = byte_count(bus.mem_len);
                        cnt_d    = '0;
                        data_d   = ZERO_WORD;
                        busy_d   = True;
                        if (bus.mem_wr) begin
                            state_d    = MEM_WR;
                            wdata_d    = bus.mem_wdata;
                            ram_wr_d   = True;
                            ram_dout_d = bus.mem_wdata[RAM_DW-1:0];
                        end else begin
                            state_d = MEM_RD;
                        end
                    end else if (bus.if_req && !flush) begin
                        state_d  = IF_RD;
                        addr_d   = bus.if_addr;
                        ram_a_d  = bus.if_addr;
                        nbytes_d = 3'(NB);
                        cnt_d    = '0;
                        data_d   = ZERO_WORD;
                        busy_d   = True;
                    end
                end
            end

            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && flush) begin
                    state_d  = IDLE;
                    busy_d   = False;
                    ram_wr_d = False;
                end else begin
                    cnt_d = step;
                    if (step < nbytes_q) begin
                        ram_a_d = addr_q + ADDR_W'(step);
                    end
                    // byte addressed at edge k-2 is on ram_din now
                    if (step >= 3'd2) begin
                        for (int unsigned b = 0; b < NB; b++) begin
                            if (b + 1 == 32'(cnt_q)) begin
                                data_d[RAM_DW*b +: RAM_DW] = bus.ram_din;
                            end
                        end
                    end
                    if (step == nbytes_q + 3'd1) begin
                        state_d = IDLE;
                        busy_d  = False;
                        if (state_q == IF_RD) begin
                            if_done_d = True;
                            if_inst_d = data_d;
                        end else begin
                            mem_done_d  = True;
                            mem_rdata_d = data_d;
                        end
                    end
                end
            end

            MEM_WR: begin
                cnt_d = step;
                if (step < nbytes_q) begin
                    ram_a_d = addr_q + ADDR_W'(step);
                    for (int unsigned b = 0; b < NB; b++) begin
                        if (b == 32'(step)) begin
                            ram_dout_d = wdata_q[RAM_DW*b +: RAM_DW];
                        end
                    end
                end else begin
                    ram_wr_d   = False;
                    mem_done_d = True;
                    state_d    = IDLE;
                    busy_d     = False;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            addr_q      <= '0;
            ram_a_q     <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            addr_q      <= addr_d;
            ram_a_q     <= ram_a_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random transactions, each checked
// against a byte-array memory model and the transfer-latency rules.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32), .RAM_DW(8)) bus ();

    mem_ctrl #(.ADDR_W(32), .DATA_W(32), .RAM_DW(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .flush(flush),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_if;
    logic [31:0] last_mem;
    logic [7:0]  ref_mem [0:65535];

    // RAM contents before any store; a few addresses carry directed values
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h0100: return 8'h13;
            16'h0101: return 8'h05;
            16'h0102: return 8'hA0;
            16'h0103: return 8'h00;
            16'h0030: return 8'hF0;
            default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
        endcase
    endfunction

    logic [7:0] ram    [0:65535];
    bit         ram_wv [0:65535];

    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        return ram_wv[a] ? ram[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (rdy) begin
            if (bus.ram_wr) begin
                ram[bus.ram_a[15:0]]    <= bus.ram_dout;
                ram_wv[bus.ram_a[15:0]] <= 1'b1;
            end
            bus.ram_din <= ram_rd(bus.ram_a[15:0]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_of(input bit is_if, input logic [1:0] len);
        if (is_if) return 4;
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // One complete request/done handshake; freeze_at/flush_at are active-edge indices or -1
    task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int freeze_at, input int flush_at);
        int          n;
        int          waited;
        int          lat;
        int          frozen;
        bit          seen;
        logic [31:0] exp;
        logic [31:0] hold_a;
        logic [15:0] a;

        n   = n_of(is_if, len);
        exp = '0;
        for (int b = 0; b < n; b++) begin
            a = 16'(addr + 32'(b));
            if (wr) ref_mem[a] = 8'((wdata >> (8 * b)) & 32'hFF);
            else    exp = exp | (32'(ref_mem[a]) << (8 * b));
        end

        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_wr    = wr;
            bus.mem_len   = len;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
        end

        waited = 0;
        while (!bus.busy && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_wait", 32'(waited), 32'd1);

        lat = 0;
        frozen = 0;
        seen = 1'b0;
        while (!seen && lat < 30) begin
            if (lat < n) begin
                check("ram_a", bus.ram_a, addr + 32'(lat));
                check("ram_wr", 32'(bus.ram_wr), 32'(wr));
                if (wr) check("ram_dout", 32'(bus.ram_dout), (wdata >> (8 * lat)) & 32'hFF);
            end
            if (lat == freeze_at) begin
                hold_a = bus.ram_a;
                rdy = 1'b0;
                repeat (3) begin
                    tick();
                    frozen++;
                    check("freeze_ram_a", bus.ram_a, hold_a);
                end
                rdy = 1'b1;
            end
            if (lat == flush_at) flush = 1'b1;
            tick();
            flush = 1'b0;
            lat++;
            seen = is_if ? bus.if_done : bus.mem_done;
        end

        check("done_latency", 32'(lat + frozen), 32'((wr ? n : n + 1) + frozen));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("other_done", 32'(is_if ? bus.mem_done : bus.if_done), 32'd0);
        if (is_if) begin
            check("if_inst", bus.if_inst, exp);
            check("mem_rdata_hold", bus.mem_rdata, last_mem);
            last_if = exp;
        end else begin
            if (!wr) begin
                check("mem_rdata", bus.mem_rdata, exp);
                last_mem = exp;
            end else begin
                check("mem_rdata_hold", bus.mem_rdata, last_mem);
            end
            check("if_inst_hold", bus.if_inst, last_if);
        end

        if (is_if) bus.if_req = 1'b0;
        else       bus.mem_req = 1'b0;
        tick();
        check("done_pulse", 32'(is_if ? bus.if_done : bus.mem_done), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("data_hold", is_if ? bus.if_inst : bus.mem_rdata, is_if ? last_if : last_mem);

        if (wr) begin
            for (int b = 0; b < n; b++) begin
                a = 16'(addr + 32'(b));
                check("ram_store", 32'(ram_rd(a)), 32'(ref_mem[a]));
            end
        end
    endtask

    initial begin
        bit          seen_done;
        int          kind;
        int          n;
        logic [1:0]  len;
        logic [31:0] addr;

        rst           = 1'b0;
        rdy           = 1'b1;
        flush         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_len   = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        last_if       = '0;
        last_mem      = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

        repeat (2) tick();
        check("rst_if_done", 32'(bus.if_done), 32'd0);
        check("rst_mem_done", 32'(bus.mem_done), 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        check("rst_ram_a", bus.ram_a, 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        rst = 1'b1;
        tick();

        run_txn(1'b1, 1'b0, LEN_W, 32'h0000_0100, 32'd0, -1, -1);
        check("fetch_word", bus.if_inst, 32'h00A0_0513);

        // IF held pending while MEM is served, then taken after the done cycle
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        run_txn(1'b0, 1'b0, LEN_W, 32'h0000_1000, 32'd0, -1, -1);
        run_txn(1'b1, 1'b0, LEN_W, 32'h0000_0200, 32'd0, -1, -1);

        run_txn(1'b0, 1'b1, LEN_H, 32'h0000_1002, 32'hDEAD_BEEF, -1, -1);
        check("store_neighbour", 32'(ram_rd(16'h1004)), 32'(init_byte(16'h1004)));
        check("store_lo", 32'(ram_rd(16'h1002)), 32'hEF);

        run_txn(1'b0, 1'b0, LEN_B, 32'h0000_0030, 32'd0, -1, -1);
        check("byte_zext", bus.mem_rdata, 32'h0000_00F0);

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        flush       = 1'b1;
        tick();
        check("flush_blocks_accept", 32'(bus.busy), 32'd0);
        bus.if_req = 1'b0;
        flush      = 1'b0;
        tick();

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0500;
        tick();
        check("flush_fetch_started", 32'(bus.busy), 32'd1);
        tick();
        flush = 1'b1;
        tick();
        check("flush_to_idle", 32'(bus.busy), 32'd0);
        flush      = 1'b0;
        bus.if_req = 1'b0;
        seen_done  = bus.if_done;
        repeat (6) begin
            tick();
            seen_done = seen_done | bus.if_done;
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        run_txn(1'b1, 1'b0, LEN_W, 32'h0000_0400, 32'd0, -1, -1);

        run_txn(1'b0, 1'b0, LEN_W, 32'h0000_3010, 32'd0, 2, -1);
        run_txn(1'b0, 1'b0, LEN_W, 32'hFFFF_FFFE, 32'd0, -1, -1);
        run_txn(1'b0, 1'b0, 2'b11, 32'h0000_3020, 32'd0, -1, -1);
        run_txn(1'b0, 1'b0, LEN_H, 32'h0000_3031, 32'd0, -1, 1);

        // asynchronous reset between edges in the middle of a word store
        bus.mem_req   = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_len   = LEN_W;
        bus.mem_addr  = 32'h0000_2000;
        bus.mem_wdata = 32'h1234_5678;
        tick();
        tick();
        check("store_in_flight", 32'(bus.ram_wr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("arst_ram_a", bus.ram_a, 32'd0);
        check("arst_ram_dout", 32'(bus.ram_dout), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_if_inst", bus.if_inst, 32'd0);
        check("arst_mem_rdata", bus.mem_rdata, 32'd0);
        bus.mem_req = 1'b0;
        seen_done = 1'b0;
        repeat (3) begin
            tick();
            seen_done = seen_done | bus.mem_done | bus.if_done;
        end
        rst = 1'b1;
        repeat (4) begin
            tick();
            seen_done = seen_done | bus.mem_done | bus.if_done | bus.busy;
        end
        check("arst_no_done", 32'(seen_done), 32'd0);
        last_if  = '0;
        last_mem = '0;

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            len  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           addr = 32'h0000_3000 + 32'($urandom_range(0, 255));
            n = n_of(kind == 0, len);
            run_txn(kind == 0, kind == 2, len, addr, $urandom(),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1,
                    (kind != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
